// File: rtl/mmu_pkg.sv
// Shared MMU types: PTW/LSU <-> dcache request/response records and the
// state and owner encodings used by the dcache port arbiter.
package mmu_pkg;

  localparam int PADDR_W = 40;
  localparam int DATA_W  = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY
  } arb_state_t;

  typedef enum logic {
    ARB_PTW,
    ARB_LSU
  } arb_owner_t;

  typedef struct packed {
    logic               valid;
    logic               phys;
    logic [4:0]         cmd;
    logic [2:0]         typ;
    logic [PADDR_W-1:0] addr;
    logic               kill;
    logic [DATA_W-1:0]  data;
  } ptw_dmem_comm_t;

  typedef struct packed {
    logic              valid;
    logic              nack;
    logic [DATA_W-1:0] data;
  } dmem_resp_t;

  typedef struct packed {
    logic       dmem_ready;
    dmem_resp_t resp;
  } dmem_ptw_comm_t;

endpackage

// File: rtl/ptw_dmem_arbiter.sv
// Shares the single dcache request port between the page-table walker and the
// LSU: one outstanding transaction, PTW priority with LSU anti-starvation.
module ptw_dmem_arbiter
  import mmu_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int RESP_TIMEOUT = 256,
  parameter bit PTW_PRIO     = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  ptw_dmem_comm_t ptw_dmem_comm_i,
  output dmem_ptw_comm_t dmem_ptw_comm_o,
  input  ptw_dmem_comm_t lsu_dmem_comm_i,
  output dmem_ptw_comm_t dmem_lsu_comm_o,
  output ptw_dmem_comm_t arb_dmem_comm_o,
  input  dmem_ptw_comm_t dmem_arb_comm_i,
  input  logic           flush_i,
  output logic           timeout_o,
  output logic           pmu_ptw_stall_o
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int TIMER_W  = $clog2(RESP_TIMEOUT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(RESP_TIMEOUT - 1);

  arb_state_t           state_q, state_d;
  arb_owner_t           owner_q, owner_d;
  arb_owner_t           rr_last_q, rr_last_d;
  logic [STARVE_W-1:0]  starve_q, starve_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;

  arb_owner_t     winner;
  arb_owner_t     sel;
  ptw_dmem_comm_t sel_req;
  logic           accept;
  logic           dcache_resp;
  logic           watchdog_fire;

  function automatic arb_owner_t pick_winner(input logic ptw_v, input logic lsu_v,
                                             input logic starved, input arb_owner_t rr_last);
    if (!lsu_v)  return ARB_PTW;
    if (!ptw_v)  return ARB_LSU;
    if (starved) return ARB_LSU;
    if (PTW_PRIO) return ARB_PTW;
    return (rr_last == ARB_PTW) ? ARB_LSU : ARB_PTW;
  endfunction

  // Grant selection: free choice in S_IDLE, locked to the owner otherwise.
  always_comb begin
    winner = pick_winner(ptw_dmem_comm_i.valid, lsu_dmem_comm_i.valid,
                         starve_q == STARVE_MAX, rr_last_q);
    if (rst_i)                  sel = ARB_PTW;
    else if (state_q == S_IDLE) sel = winner;
    else                        sel = owner_q;
    sel_req       = (sel == ARB_LSU) ? lsu_dmem_comm_i : ptw_dmem_comm_i;
    accept        = (state_q != S_BUSY) && sel_req.valid && dmem_arb_comm_i.dmem_ready;
    dcache_resp   = dmem_arb_comm_i.resp.valid || dmem_arb_comm_i.resp.nack;
    watchdog_fire = (state_q == S_BUSY) && (timer_q == TIMER_LAST) && !dcache_resp;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      owner_q   <= ARB_PTW;
      rr_last_q <= ARB_LSU;
      starve_q  <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      starve_q  <= starve_d;
      timer_q   <= timer_d;
    end
  end

  // NOTE: every next-state variable gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    starve_d  = starve_q;
    timer_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (sel_req.valid) begin
          owner_d = sel;
          state_d = dmem_arb_comm_i.dmem_ready ? S_BUSY : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!sel_req.valid)                  state_d = S_IDLE;
        else if (dmem_arb_comm_i.dmem_ready) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (dcache_resp || watchdog_fire) state_d = S_IDLE;
        else                              timer_d = timer_q + TIMER_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) rr_last_d = sel;

    if (flush_i) begin
      starve_d  = '0;
      rr_last_d = ARB_LSU;
    end else if (accept && sel == ARB_LSU) begin
      starve_d = '0;
    end else if (state_q == S_IDLE && lsu_dmem_comm_i.valid && winner != ARB_LSU
                 && starve_q != STARVE_MAX) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  // Responses only reach the owner, and only while a transaction is open.
  always_comb begin
    dmem_resp_t fwd;
    logic       ready_gate;

    arb_dmem_comm_o       = sel_req;
    arb_dmem_comm_o.valid = !rst_i && (state_q != S_BUSY) && sel_req.valid;

    dmem_ptw_comm_o = '0;
    dmem_lsu_comm_o = '0;
    ready_gate = !rst_i && (state_q != S_BUSY) && dmem_arb_comm_i.dmem_ready;
    if (sel == ARB_LSU) dmem_lsu_comm_o.dmem_ready = ready_gate;
    else                dmem_ptw_comm_o.dmem_ready = ready_gate;

    fwd = '0;
    if (!rst_i && state_q == S_BUSY) begin
      fwd.nack  = dmem_arb_comm_i.resp.nack || watchdog_fire;
      fwd.valid = dmem_arb_comm_i.resp.valid && !dmem_arb_comm_i.resp.nack;
      fwd.data  = fwd.valid ? dmem_arb_comm_i.resp.data : '0;
    end
    if (owner_q == ARB_LSU) dmem_lsu_comm_o.resp = fwd;
    else                    dmem_ptw_comm_o.resp = fwd;

    timeout_o       = !rst_i && watchdog_fire;
    pmu_ptw_stall_o = !rst_i && ptw_dmem_comm_i.valid
                      && (state_q != S_IDLE || winner != ARB_PTW);
  end

endmodule

// File: tb/tb_ptw_dmem_arbiter.sv
// Directed and randomized bench for ptw_dmem_arbiter, checked every cycle
// against a transaction-level reference model.
module tb_ptw_dmem_arbiter;
  import mmu_pkg::*;

  localparam int STARVE = 8;
  localparam int TMO    = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           timeout;
  logic           pmu;
  ptw_dmem_comm_t ptw_req, lsu_req, arb_req;
  dmem_ptw_comm_t ptw_rsp, lsu_rsp, dc_rsp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ptw_dmem_arbiter #(
    .STARVE_LIMIT(STARVE),
    .RESP_TIMEOUT(TMO),
    .PTW_PRIO    (1'b1)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ptw_dmem_comm_i(ptw_req),
    .dmem_ptw_comm_o(ptw_rsp),
    .lsu_dmem_comm_i(lsu_req),
    .dmem_lsu_comm_o(lsu_rsp),
    .arb_dmem_comm_o(arb_req),
    .dmem_arb_comm_i(dc_rsp),
    .flush_i        (flush),
    .timeout_o      (timeout),
    .pmu_ptw_stall_o(pmu)
  );

  // Reference model: open transaction (-1 = none), locked requester, counters.
  // Requesters are numbered 0 = PTW, 1 = LSU.
  int m_open_owner;
  int m_locked;
  int m_owner;
  int m_waited;
  int m_starve;
  int m_last;
  int m_win;

  dmem_ptw_comm_t e_ptw, e_lsu;
  ptw_dmem_comm_t e_arb;
  logic           e_to, e_pmu;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int m_pick(input bit pv, input bit lv);
    if (pv && lv) return (m_starve >= STARVE) ? 1 : 0;
    return lv ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_open_owner = -1;
    m_locked     = -1;
    m_owner      = 0;
    m_waited     = 0;
    m_starve     = 0;
    m_last       = 1;
  endtask

  task automatic model_outputs();
    dmem_resp_t r;
    int         who;
    bit         pv, lv;
    pv    = ptw_req.valid;
    lv    = lsu_req.valid;
    e_ptw = '0;
    e_lsu = '0;
    e_to  = 1'b0;
    e_pmu = 1'b0;
    m_win = m_pick(pv, lv);
    if (rst) begin
      e_arb       = ptw_req;
      e_arb.valid = 1'b0;
      return;
    end
    if (m_open_owner >= 0) begin
      e_arb       = (m_open_owner != 0) ? lsu_req : ptw_req;
      e_arb.valid = 1'b0;
      r     = '0;
      e_to  = (m_waited == TMO - 1) && !dc_rsp.resp.valid && !dc_rsp.resp.nack;
      r.nack  = dc_rsp.resp.nack || e_to;
      r.valid = dc_rsp.resp.valid && !dc_rsp.resp.nack;
      r.data  = r.valid ? dc_rsp.resp.data : '0;
      if (m_open_owner != 0) e_lsu.resp = r;
      else                   e_ptw.resp = r;
    end else begin
      who   = (m_locked >= 0) ? m_locked : m_win;
      e_arb = (who != 0) ? lsu_req : ptw_req;
      if (who != 0) e_lsu.dmem_ready = dc_rsp.dmem_ready;
      else          e_ptw.dmem_ready = dc_rsp.dmem_ready;
    end
    e_pmu = pv && (m_open_owner >= 0 || m_locked >= 0 || m_win != 0);
  endtask

  task automatic model_update();
    int who;
    bit who_valid;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_open_owner >= 0) begin
      m_waited++;
      if (dc_rsp.resp.valid || dc_rsp.resp.nack || m_waited == TMO) begin
        m_open_owner = -1;
        m_waited     = 0;
      end
    end else begin
      who       = (m_locked >= 0) ? m_locked : m_pick(ptw_req.valid, lsu_req.valid);
      who_valid = (who != 0) ? lsu_req.valid : ptw_req.valid;
      if (m_locked < 0 && lsu_req.valid && who != 1 && m_starve < STARVE) m_starve++;
      if (who_valid && dc_rsp.dmem_ready) begin
        m_open_owner = who;
        m_owner      = who;
        m_last       = who;
        m_locked     = -1;
        if (who == 1) m_starve = 0;
      end else if (who_valid) begin
        m_locked = who;
      end else begin
        m_locked = -1;
      end
    end
    if (flush) begin
      m_starve = 0;
      m_last   = 1;
    end
  endtask

  task automatic check_cycle();
    @(negedge clk);
    model_outputs();
    chk("ptw_view", ptw_rsp, e_ptw);
    chk("lsu_view", lsu_rsp, e_lsu);
    chk("dcache_req", arb_req, e_arb);
    chk("timeout", timeout, e_to);
    chk("pmu_stall", pmu, e_pmu);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    check_cycle();
    advance();
  endtask

  task automatic rand_req(output ptw_dmem_comm_t r, input int pct);
    r.valid = ($urandom_range(0, 99) < pct);
    r.phys  = 1'($urandom);
    r.cmd   = 5'($urandom);
    r.typ   = 3'($urandom);
    r.addr  = {8'($urandom), 32'($urandom)};
    r.kill  = 1'($urandom);
    r.data  = {32'($urandom), 32'($urandom)};
  endtask

  task automatic drain();
    ptw_req.valid      = 1'b0;
    lsu_req.valid      = 1'b0;
    dc_rsp             = '0;
    dc_rsp.resp.valid  = 1'b1;
    step();
    dc_rsp = '0;
    step();
  endtask

  initial begin
    int lsu_first;
    model_reset();
    rst     = 1'b1;
    flush   = 1'b0;
    ptw_req = '0;
    lsu_req = '0;
    dc_rsp  = '0;

    // Reset state
    check_cycle();
    chk("rst_arb_valid", arb_req.valid, 1'b0);
    chk("rst_ptw_view", ptw_rsp, '0);
    advance();
    rst = 1'b0;
    step();

    // 1: PTW-only read, response three cycles after acceptance
    rand_req(ptw_req, 100);
    ptw_req.addr      = 40'h00_8000_1000;
    ptw_req.cmd       = 5'd0;
    dc_rsp.dmem_ready = 1'b1;
    check_cycle();
    chk("t1_accept", ptw_rsp.dmem_ready, 1'b1);
    chk("t1_addr", arb_req.addr, 40'h00_8000_1000);
    advance();
    ptw_req.valid = 1'b0;
    dc_rsp        = '0;
    step();
    step();
    dc_rsp.resp.valid = 1'b1;
    dc_rsp.resp.data  = 64'hdead_beef_0123_4567;
    check_cycle();
    chk("t1_resp", ptw_rsp.resp.valid, 1'b1);
    chk("t1_data", ptw_rsp.resp.data, 64'hdead_beef_0123_4567);
    chk("t1_lsu_zero", lsu_rsp, '0);
    advance();
    dc_rsp = '0;
    step();

    // 2: PTW back-to-back while LSU starves
    rand_req(ptw_req, 100);
    rand_req(lsu_req, 100);
    dc_rsp.dmem_ready = 1'b1;
    dc_rsp.resp.valid = 1'b1;
    lsu_first = -1;
    for (int i = 0; i < 20; i++) begin
      check_cycle();
      if (lsu_first < 0 && lsu_rsp.dmem_ready) lsu_first = i;
      advance();
      if (lsu_first == i) lsu_req.valid = 1'b0;
    end
    chk("t2_lsu_grant_cycle", 32'(lsu_first), 32'd16);
    lsu_req.valid = 1'b1;
    check_cycle();
    chk("t2_ptw_wins_again", ptw_rsp.dmem_ready, 1'b1);
    chk("t2_lsu_denied", lsu_rsp.dmem_ready, 1'b0);
    advance();
    drain();

    // 3: PTW locked in S_ISSUE while dcache stalls
    rand_req(ptw_req, 100);
    rand_req(lsu_req, 100);
    lsu_req.addr = ~ptw_req.addr;
    dc_rsp       = '0;
    for (int i = 0; i < 4; i++) begin
      check_cycle();
      chk("t3_lsu_ready", lsu_rsp.dmem_ready, 1'b0);
      chk("t3_grant_ptw", arb_req.addr, ptw_req.addr);
      advance();
    end
    dc_rsp.dmem_ready = 1'b1;
    check_cycle();
    chk("t3_ptw_accept", ptw_rsp.dmem_ready, 1'b1);
    advance();
    drain();

    // 4: LSU owns S_BUSY and receives a nack
    flush = 1'b1;
    step();
    flush = 1'b0;
    rand_req(lsu_req, 100);
    ptw_req.valid     = 1'b0;
    dc_rsp.dmem_ready = 1'b1;
    step();
    lsu_req.valid    = 1'b0;
    ptw_req.valid    = 1'b1;
    dc_rsp.resp.nack = 1'b1;
    check_cycle();
    chk("t4_lsu_nack", lsu_rsp.resp.nack, 1'b1);
    chk("t4_ptw_quiet", ptw_rsp, '0);
    advance();
    dc_rsp.resp.nack = 1'b0;
    check_cycle();
    chk("t4_ptw_accept", ptw_rsp.dmem_ready, 1'b1);
    advance();
    drain();

    // 5: watchdog fires, late response is dropped
    rand_req(ptw_req, 100);
    dc_rsp.dmem_ready = 1'b1;
    step();
    ptw_req.valid = 1'b0;
    dc_rsp        = '0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 20) dc_rsp.resp.valid = 1'b1;
      check_cycle();
      if (i == 16) begin
        chk("t5_timeout", timeout, 1'b1);
        chk("t5_owner_nack", ptw_rsp.resp.nack, 1'b1);
      end
      if (i == 20) begin
        chk("t5_late_ptw", ptw_rsp.resp, '0);
        chk("t5_late_lsu", lsu_rsp.resp, '0);
      end
      advance();
    end
    dc_rsp = '0;

    // 6: reset while a transaction is open
    rand_req(ptw_req, 100);
    dc_rsp.dmem_ready = 1'b1;
    step();
    ptw_req.valid     = 1'b0;
    dc_rsp.resp.valid = 1'b1;
    rst               = 1'b1;
    check_cycle();
    chk("t6_ptw_zero", ptw_rsp, '0);
    chk("t6_lsu_zero", lsu_rsp, '0);
    advance();
    rst    = 1'b0;
    dc_rsp = '0;
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_req(ptw_req, 55);
      rand_req(lsu_req, 55);
      dc_rsp.dmem_ready = ($urandom_range(0, 99) < 50);
      dc_rsp.resp.valid = ($urandom_range(0, 99) < 12);
      dc_rsp.resp.nack  = ($urandom_range(0, 99) < 4);
      dc_rsp.resp.data  = {32'($urandom), 32'($urandom)};
      flush             = ($urandom_range(0, 99) < 2);
      rst               = ($urandom_range(0, 999) < 3);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ptw_dmem_arbiter.md
Name: ptw_dmem_arbiter

Overview:
- Shares the single data-cache request port between the page-table walker and the core LSU.
- Sits between `ptw` (its `ptw_dmem_comm_o` / `dmem_ptw_comm_i` pair) and the dcache.
- Grants one requester at a time, allows one outstanding transaction, and routes `resp`/`nack` only to the owner.
- Adds PTW priority with LSU anti-starvation and a response-timeout watchdog.

Parameters:
- STARVE_LIMIT, 8: consecutive cycles the LSU may be valid-but-denied before it is forced to win.
- RESP_TIMEOUT, 256: cycles in S_BUSY without `resp.valid`/`resp.nack` before the arbiter aborts.
- PTW_PRIO, 1: 1 = PTW wins ties (subject to STARVE_LIMIT); 0 = round-robin on the last winner.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous reset, active-high
- ptw_dmem_comm_i  input  ptw_dmem_comm_t  PTW request (valid/phys/cmd/typ/addr/kill/data)
- dmem_ptw_comm_o  output  dmem_ptw_comm_t  PTW view: dmem_ready, resp.valid/nack/data
- lsu_dmem_comm_i  input  ptw_dmem_comm_t  LSU request, same format
- dmem_lsu_comm_o  output  dmem_ptw_comm_t  LSU view, same format
- arb_dmem_comm_o  output  ptw_dmem_comm_t  muxed request to dcache
- dmem_arb_comm_i  input  dmem_ptw_comm_t  dcache ready/response
- flush_i  input  1  TLB/PTW flush (csr flush); clears starvation count and round-robin pointer
- timeout_o  output  1  one-cycle pulse when the watchdog fires
- pmu_ptw_stall_o  output  1  PTW valid and not granted this cycle

Behaviour:
- Reset: state = S_IDLE, owner = PTW, rr_last = LSU, starve_cnt = 0, timer = 0.
  - All outputs 0, except `arb_dmem_comm_o` payload, which equals the PTW payload with valid = 0.
- Winner in S_IDLE, combinational:
  - Only one requester valid → it wins.
  - Both valid and starve_cnt == STARVE_LIMIT → LSU wins.
  - Both valid otherwise → PTW_PRIO ? PTW : the requester that is not rr_last.
- Request/ready routing:
  - `arb_dmem_comm_o` carries the selected requester's payload and valid.
  - The winner's `dmem_ready` = `dmem_arb_comm_i.dmem_ready`; the loser's `dmem_ready` = 0.
- States:
  - S_IDLE: no grant is held.
    - Winner valid and dcache ready → accept the same cycle, record owner, rr_last = owner, go to S_BUSY.
    - Winner valid and not ready → lock owner, go to S_ISSUE.
  - S_ISSUE: grant stays locked to owner (no switching); only the owner's request is forwarded.
    - Owner valid and ready → S_BUSY.
    - Owner drops valid → S_IDLE with no transaction.
  - S_BUSY: `arb_dmem_comm_o.valid` = 0; both `dmem_ready` = 0.
    - `resp.valid` or `resp.nack` is forwarded combinationally (zero latency) to the owner only; the other side sees resp.valid = 0 and nack = 0. Then go to S_IDLE.
    - A new grant is possible at the earliest on the next cycle (one-cycle turnaround).
    - `resp.valid` and `resp.nack` in the same cycle: nack takes precedence; resp.valid is suppressed.
- Watchdog: timer increments in S_BUSY and clears on leaving it.
  - At timer == RESP_TIMEOUT-1 with no response: drive a `nack` pulse to the owner, pulse `timeout_o`, go to S_IDLE.
  - A late dcache response arriving in S_IDLE is dropped (forwarded to nobody).
- Starvation counter (saturating at STARVE_LIMIT):
  - Increments each cycle LSU valid is denied in S_IDLE.
  - Clears when the LSU is accepted, or on `flush_i`.
- `flush_i`:
  - Does not abort S_ISSUE or S_BUSY; the transaction completes normally.
  - Only resets starve_cnt and rr_last.
- Mid-operation reset returns to the reset state immediately; an outstanding dcache response is then dropped.
- `pmu_ptw_stall_o` = PTW valid && (state != S_IDLE || winner != PTW).

Decomposition:
- mmu_pkg: add `arb_state_t` enum {S_IDLE, S_ISSUE, S_BUSY} and `arb_owner_t` {ARB_PTW, ARB_LSU}.
  - Reuse `ptw_dmem_comm_t` / `dmem_ptw_comm_t` unchanged.
- No sub-module needed.
  - Winner selection is a small function inside the block.
  - The watchdog is an inline counter of width $clog2(RESP_TIMEOUT+1).

Test Plan:
1. PTW-only read, addr 0x8000_1000, dcache ready at cycle 0, `resp.valid` at cycle 3 → `dmem_ptw_comm_o.resp.valid` at cycle 3, `dmem_lsu_comm_o` all zero throughout.
2. PTW and LSU valid together, PTW_PRIO=1, LSU held 9 cycles while PTW issues back-to-back → LSU granted in the S_IDLE cycle after starve_cnt reaches 8; starve_cnt returns to 0.
3. Winner PTW, dcache not ready 4 cycles while LSU valid → grant stays PTW (S_ISSUE), LSU `dmem_ready` = 0; PTW accepted on the 5th cycle.
4. LSU owns S_BUSY, dcache returns `nack` → nack seen only on `dmem_lsu_comm_o`; a PTW request is accepted no earlier than the next cycle.
5. RESP_TIMEOUT=16, no response → at the 16th S_BUSY cycle `timeout_o` = 1 and owner gets nack; a late `resp.valid` at cycle 20 reaches neither side.
6. `rst_i` asserted while in S_BUSY → next edge: state S_IDLE, all resp/ready outputs 0, starve_cnt = 0.
